// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle three-way magnitude comparator, MSB-first, D bits per cycle.
// Define CMP_SIGNED_EN to honour signed_mode (two's-complement compare).
module cmp_seq #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         a_lt_b,
    output logic         a_eq_b,
    output logic         a_gt_b
);

    localparam int NDIG = N / D;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] a_q;
    logic [N-1:0] a_d;
    logic [N-1:0] b_q;
    logic [N-1:0] b_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic         done_q;
    logic         done_d;
    logic         lt_q;
    logic         lt_d;
    logic         eq_q;
    logic         eq_d;
    logic         gt_q;
    logic         gt_d;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [D-1:0] dig_a;
    logic [D-1:0] dig_b;

    // Flipping the sign bits maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
    assign a_in = {a[N-1] ^ signed_mode, a[N-2:0]};
    assign b_in = {b[N-1] ^ signed_mode, b[N-2:0]};
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign a_in = a;
    assign b_in = b;
`endif

    // Operands shift left each cycle so the current digit is always on top.
    assign dig_a = a_q[N-1 -: D];
    assign dig_b = b_q[N-1 -: D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dig_a != dig_b) begin
                    lt_d    = (dig_a < dig_b);
                    gt_d    = (dig_a > dig_b);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == LAST) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                    a_d   = a_q << D;
                    b_d   = b_q << D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign a_lt_b = lt_q;
    assign a_eq_b = eq_q;
    assign a_gt_b = gt_q;

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: three cmp_seq instances on shared stimulus, checked each cycle
// against an arithmetic reference model plus directed literal cases.
module tb_cmp_seq;

`ifdef CMP_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sm;
    logic [15:0] av;
    logic [15:0] bv;

    logic busy8, done8, lt8, eq8, gt8;
    logic busy4, done4, lt4, eq4, gt4;
    logic busy1, done1, lt1, eq1, gt1;

    cmp_seq #(.N(8), .D(2)) u_d8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(av[7:0]), .b(bv[7:0]),
        .busy(busy8), .done(done8),
        .a_lt_b(lt8), .a_eq_b(eq8), .a_gt_b(gt8)
    );

    cmp_seq #(.N(16), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(av), .b(bv),
        .busy(busy4), .done(done4),
        .a_lt_b(lt4), .a_eq_b(eq4), .a_gt_b(gt4)
    );

    cmp_seq #(.N(16), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(av), .b(bv),
        .busy(busy1), .done(done1),
        .a_lt_b(lt1), .a_eq_b(eq1), .a_gt_b(gt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int nn [3] = '{8, 16, 16};
    int dd [3] = '{2, 4, 1};

    logic [4:0] obs [3];
    always_comb begin
        obs[0] = {busy8, done8, lt8, eq8, gt8};
        obs[1] = {busy4, done4, lt4, eq4, gt4};
        obs[2] = {busy1, done1, lt1, eq1, gt1};
    end

    logic       m_busy [3];
    logic       m_done [3];
    logic       m_seen [3];
    logic [2:0] m_res  [3];
    logic [2:0] m_pend [3];
    int         m_cnt  [3];
    int         n_done [3];

    // Result {lt,eq,gt} from plain integer compare; j = first differing digit (1-based).
    function automatic void predict(input int n, input int d,
                                    input logic [15:0] x, input logic [15:0] y,
                                    input logic s,
                                    output int j, output logic [2:0] r);
        longint msk;
        longint dm;
        longint xv;
        longint yv;
        bit found;
        msk = (longint'(1) << n) - 1;
        dm  = (longint'(1) << d) - 1;
        xv  = longint'(x) & msk;
        yv  = longint'(y) & msk;
        j   = n / d;
        found = 1'b0;
        for (int i = 0; i < n / d; i++) begin
            if (!found && ((((xv >> (n - d - i * d)) ^ (yv >> (n - d - i * d))) & dm) != 0)) begin
                j = i + 1;
                found = 1'b1;
            end
        end
        if (s && SEN) begin
            if (((xv >> (n - 1)) & 1) != 0) xv = xv - (longint'(1) << n);
            if (((yv >> (n - 1)) & 1) != 0) yv = yv - (longint'(1) << n);
        end
        if (xv < yv)       r = 3'b100;
        else if (xv == yv) r = 3'b010;
        else               r = 3'b001;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int j;
        logic [2:0] r;
        if (rst) begin
            for (int u = 0; u < 3; u++) begin
                m_busy[u] <= 1'b0;
                m_done[u] <= 1'b0;
                m_seen[u] <= 1'b0;
                m_res[u]  <= 3'b000;
                m_pend[u] <= 3'b000;
                m_cnt[u]  <= 0;
            end
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (m_busy[u]) begin
                    if (m_cnt[u] == 1) begin
                        m_busy[u] <= 1'b0;
                        m_done[u] <= 1'b1;
                        m_seen[u] <= 1'b1;
                        m_res[u]  <= m_pend[u];
                        n_done[u] <= n_done[u] + 1;
                    end else begin
                        m_cnt[u] <= m_cnt[u] - 1;
                    end
                end else begin
                    m_done[u] <= 1'b0;
                    if (start) begin
                        predict(nn[u], dd[u], av, bv, sm, j, r);
                        m_pend[u] <= r;
                        m_cnt[u]  <= j;
                        m_busy[u] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int u = 0; u < 3; u++) begin
                checks++;
                if (obs[u] !== {m_busy[u], m_done[u], m_res[u]}) begin
                    errors++;
                    $display("FAIL model_u%0d t=%0t got busy,done,lt,eq,gt=%b want %b",
                             u, $time, obs[u], {m_busy[u], m_done[u], m_res[u]});
                end
                if (m_seen[u]) begin
                    checks++;
                    if (!$onehot(obs[u][2:0])) begin
                        errors++;
                        $display("FAIL onehot_u%0d t=%0t got %b want one bit set",
                                 u, $time, obs[u][2:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic go(input logic [15:0] x, input logic [15:0] y, input logic s);
        av = x;
        bv = y;
        sm = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy8}, 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done8 && lat < 40);
        if (!done8) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string name, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input int exp_lat, input logic [2:0] exp_res);
        int lat;
        go(x, y, s);
        wait_done(lat);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_res"}, {29'd0, lt8, eq8, gt8}, {29'd0, exp_res});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1;
        start = 1'b0;
        sm = 1'b0;
        av = '0;
        bv = '0;
        repeat (2) @(negedge clk);
        check("reset_d8", {27'd0, obs[0]}, 32'd0);
        check("reset_d1", {27'd0, obs[2]}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run("u80_7f", 16'h80, 16'h7F, 1'b0, 1, 3'b001);
        run("s80_7f", 16'h80, 16'h7F, 1'b1, 1, SEN ? 3'b100 : 3'b001);
        run("sff_01", 16'hFF, 16'h01, 1'b1, 1, SEN ? 3'b100 : 3'b001);
        run("u12_13", 16'h12, 16'h13, 1'b0, 4, 3'b100);
        run("u5a_5a", 16'h5A, 16'h5A, 1'b0, 4, 3'b010);

        go(16'h13, 16'h12, 1'b0);
        av = 16'h00;
        bv = 16'hFF;
        start = 1'b1;
        wait_done(lat);
        check("ignore_lat", lat, 4);
        check("ignore_res", {29'd0, lt8, eq8, gt8}, 32'b001);

        go(16'h5A, 16'h5A, 1'b0);
        wait_done(lat);
        check("b2b_lat", lat, 4);
        check("b2b_res", {29'd0, lt8, eq8, gt8}, 32'b010);

        go(16'h12, 16'h13, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_d8", {27'd0, obs[0]}, 32'd0);
        check("async_rst_d4", {27'd0, obs[1]}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        run("after_rst", 16'h01, 16'h02, 1'b0, 4, 3'b100);

        repeat (4000) begin
            av = 16'($urandom);
            case ($urandom % 4)
                0: bv = av;
                1: bv = av ^ (16'h1 << ($urandom % 16));
                2: bv = 16'($urandom);
                default: bv = av ^ (16'h1 << ($urandom % 4));
            endcase
            sm = 1'($urandom % 2);
            start = (($urandom % 3) != 0);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("activity_d1", {31'd0, n_done[2] > 50}, 32'd1);
        check("activity_d4", {31'd0, n_done[1] > 50}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        for (int u = 0; u < 3; u++) n_done[u] = 0;
    end

endmodule
